// File: rtl/mem_burst_master.sv
// Burst initiator for the main memory port: turns one client request into a
// paced sequence of en/addr beats, returns read data and flags done or err.
module mem_burst_master #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32,
    parameter int ACCESS_SIZE  = 2,
    parameter int TIMEOUT      = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    req_wr,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [ACCESS_SIZE-1:0]  req_size,
    output logic                    req_ready,
    input  logic [DATA_SIZE-1:0]    wd_data,
    output logic                    wd_pop,
    output logic [DATA_SIZE-1:0]    rd_data,
    output logic                    rd_valid,
    output logic                    done,
    output logic                    err,
    output logic                    en,
    output logic                    wren,
    output logic [ADDRESS_SIZE-1:0] addr,
    output logic [DATA_SIZE-1:0]    d_in,
    output logic [ACCESS_SIZE-1:0]  acc_size,
    input  logic [DATA_SIZE-1:0]    d_out,
    input  logic                    busy,
    output logic [2:0]              dbg_state
);

    // Handshakes: a client request transfers on an edge where req && req_ready;
    // a memory beat transfers on an edge where en && !busy. Neither side may
    // change what it presents until that edge has passed.

    localparam int STALL_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_XFER  = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDRESS_SIZE-1:0] base_q, base_d;
    logic                    wr_q, wr_d;
    logic [ACCESS_SIZE-1:0]  size_q, size_d;
    logic [4:0]              beat_q, beat_d;
    logic [STALL_W-1:0]      stall_q, stall_d;
    logic                    rd_pend_q, rd_pend_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_SIZE-1:0]    rd_data_q, rd_data_d;

    logic       in_xfer;
    logic       beat_acc;
    logic       last_beat;
    logic       accept;
    logic [4:0] beat_len;

    assign in_xfer  = (state_q == S_XFER);
    assign beat_acc = in_xfer && !busy;
    assign accept   = req && (state_q == S_IDLE);

    always_comb begin
        beat_len = 5'd1;
        case (size_q[1:0])
            2'b00:   beat_len = 5'd1;
            2'b01:   beat_len = 5'd4;
            2'b10:   beat_len = 5'd8;
            default: beat_len = 5'd16;
        endcase
    end

    assign last_beat = (beat_q == beat_len - 5'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = (req_addr[1:0] == 2'b00) ? S_XFER : S_ERR;
                end
            end
            S_XFER: begin
                if (!busy) begin
                    if (last_beat) begin
                        state_d = wr_q ? S_DONE : S_DRAIN;
                    end
                end else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        base_d     = base_q;
        wr_d       = wr_q;
        size_d     = size_q;
        beat_d     = beat_q;
        stall_d    = stall_q;
        if (accept) begin
            base_d  = req_addr;
            wr_d    = req_wr;
            size_d  = req_size;
            beat_d  = 5'd0;
            stall_d = '0;
        end
        if (beat_acc) begin
            beat_d  = beat_q + 5'd1;
            stall_d = '0;
        end else if (in_xfer) begin
            stall_d = stall_q + STALL_W'(1);
        end
        // Memory returns read data the cycle after a beat is accepted.
        rd_pend_d  = beat_acc && !wr_q;
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_pend_q ? d_out : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            wr_q       <= 1'b0;
            size_q     <= '0;
            beat_q     <= 5'd0;
            stall_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            base_q     <= base_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            beat_q     <= beat_d;
            stall_q    <= stall_d;
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        en        = in_xfer;
        wren      = in_xfer && wr_q;
        addr      = in_xfer ? (base_q + (ADDRESS_SIZE'(beat_q) << 2)) : '0;
        acc_size  = in_xfer ? size_q : '0;
        d_in      = (in_xfer && wr_q) ? wd_data : '0;
        wd_pop    = beat_acc && wr_q;
        req_ready = (state_q == S_IDLE);
        done      = (state_q == S_DONE);
        err       = (state_q == S_ERR);
        rd_valid  = rd_valid_q;
        rd_data   = rd_data_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Randomised scoreboard bench for mem_burst_master with a per-beat stall plan
// and a transaction-level model of addresses, read data and completion time.
module tb_mem_burst_master;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req_wr;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_ready;
  logic [31:0] wd_data;
  logic        wd_pop;
  logic [31:0] rd_data;
  logic        rd_valid, done, err, en, wren;
  logic [31:0] addr, d_in, d_out;
  logic [1:0]  acc_size;
  logic        busy;
  logic [2:0]  dbg_state;

  mem_burst_master #(.ADDRESS_SIZE(32), .DATA_SIZE(32), .ACCESS_SIZE(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_size(req_size), .req_ready(req_ready), .wd_data(wd_data), .wd_pop(wd_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err), .en(en),
    .wren(wren), .addr(addr), .d_in(d_in), .acc_size(acc_size), .d_out(d_out),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // scoreboard
  logic [66:0] exp_beat_q[$];  // {addr, wren, acc_size, d_in}
  logic [31:0] exp_rd_q[$];
  logic [32:0] exp_cpl_q[$];   // {is_err, cycle}
  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // memory model state, shared with the stimulus tasks
  int          plan_stall[16];
  logic [31:0] wdat[16];
  int          beat_idx = 0;
  int          stall_left = 0;
  int          wd_idx = 0;

  initial begin
    bit          acc_prev, wacc_prev, racc_prev;
    logic [31:0] addr_prev;
    acc_prev = 0; wacc_prev = 0; racc_prev = 0; addr_prev = 0;
    busy = 1'b0; d_out = '0; wd_data = '0;
    forever begin
      @(negedge clk);
      if (acc_prev) begin
        beat_idx++;
        stall_left = (beat_idx < 16) ? plan_stall[beat_idx] : 0;
        if (wacc_prev) wd_idx++;
      end
      d_out   = racc_prev ? mem_val(addr_prev) : $urandom;
      wd_data = wdat[(wd_idx > 15) ? 15 : wd_idx];
      if (en) begin
        busy = (stall_left > 0);
        if (busy) stall_left--;
      end else begin
        busy = 1'($urandom_range(0, 1));
      end
      acc_prev  = en && !busy;
      wacc_prev = en && !busy && wren;
      racc_prev = en && !busy && !wren;
      addr_prev = addr;
    end
  end

  // monitor
  initial begin
    logic [66:0] h;
    logic [32:0] c;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      #3;
      if (en) begin
        check_eq("beat_expected", 64'(exp_beat_q.size() != 0), 64'd1);
        if (exp_beat_q.size() != 0) begin
          h = exp_beat_q[0];
          check_eq("beat_addr", addr, h[66:35]);
          check_eq("beat_wren", wren, h[34]);
          check_eq("beat_acc_size", acc_size, h[33:32]);
          if (h[34]) check_eq("beat_d_in", d_in, h[31:0]);
          check_eq("beat_wd_pop", wd_pop, h[34] && !busy);
          if (!busy) void'(exp_beat_q.pop_front());
        end
      end else begin
        check_eq("wd_pop_no_en", wd_pop, 0);
      end
      if (rd_valid) begin
        check_eq("rd_expected", 64'(exp_rd_q.size() != 0), 64'd1);
        if (exp_rd_q.size() != 0) begin
          r = exp_rd_q.pop_front();
          check_eq("rd_data", rd_data, r);
        end
      end
      if (done || err) begin
        check_eq("cpl_expected", 64'(exp_cpl_q.size() != 0), 64'd1);
        if (exp_cpl_q.size() != 0) begin
          c = exp_cpl_q.pop_front();
          check_eq("cpl_err", err, c[32]);
          check_eq("cpl_done", done, !c[32]);
          check_eq("cpl_cycle", cyc, c[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_idle();
    int waited = 0;
    @(negedge clk); #4;
    while (!req_ready && waited < 100) begin
      @(negedge clk); #4;
      waited++;
    end
    check_eq("req_ready_wait", req_ready, 1);
  endtask

  task automatic clear_plan();
    for (int k = 0; k < 16; k++) begin
      plan_stall[k] = 0;
      wdat[k] = $urandom;
    end
  endtask

  task automatic run_xfer(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                          input bit hold_req);
    int n, k_ab, s_sum, t1, waited, left_exp;
    bit abort;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 4 : (sz == 2'd2) ? 8 : 16;
    wait_idle();
    t1 = cyc + 1;
    k_ab = n;
    s_sum = 0;
    for (int k = 0; k < n; k++) begin
      if (plan_stall[k] >= TMO) begin
        k_ab = k;
        break;
      end
      s_sum += plan_stall[k];
    end
    abort = (k_ab < n);
    left_exp = 0;
    if (a[1:0] != 2'b00) begin
      exp_cpl_q.push_back({1'b1, 32'(t1)});
    end else begin
      for (int k = 0; k < n && k <= k_ab; k++) begin
        exp_beat_q.push_back({a + 32'(4 * k), wr, sz, wdat[k]});
        if (!wr && k < k_ab) exp_rd_q.push_back(mem_val(a + 32'(4 * k)));
      end
      if (abort) begin
        exp_cpl_q.push_back({1'b1, 32'(t1 + k_ab + s_sum + TMO)});
        left_exp = 1;
      end else begin
        exp_cpl_q.push_back({1'b0, 32'(t1 + n + s_sum + (wr ? 0 : 1))});
      end
    end
    beat_idx = 0;
    stall_left = plan_stall[0];
    wd_idx = 0;
    req = 1'b1; req_wr = wr; req_addr = a; req_size = sz;
    @(negedge clk); #4;
    if (hold_req) begin
      req_addr = $urandom | 32'h1;
      req_wr = 1'($urandom_range(0, 1));
    end else begin
      req = 1'b0;
      req_addr = $urandom;
    end
    waited = 0;
    while (!(done || err) && waited < 300) begin
      @(negedge clk); #4;
      waited++;
    end
    check_eq("cpl_seen", done || err, 1);
    check_eq("en_at_cpl", en, 0);
    req = 1'b0;
    @(negedge clk); #4;
    check_eq("req_ready_after", req_ready, 1);
    check_eq("en_after", en, 0);
    repeat (2) @(negedge clk);
    #4;
    check_eq("beats_left", exp_beat_q.size(), left_exp);
    check_eq("rd_left", exp_rd_q.size(), 0);
    check_eq("cpl_left", exp_cpl_q.size(), 0);
    exp_beat_q.delete();
    exp_rd_q.delete();
    exp_cpl_q.delete();
  endtask

  task automatic run_reset_case();
    logic [31:0] a;
    int waited;
    a = 32'hFFFFFFF8;
    clear_plan();
    wait_idle();
    for (int k = 0; k <= 5; k++) exp_beat_q.push_back({a + 32'(4 * k), 1'b0, 2'b11, wdat[k]});
    for (int k = 0; k <= 3; k++) exp_rd_q.push_back(mem_val(a + 32'(4 * k)));
    beat_idx = 0; stall_left = 0; wd_idx = 0;
    req = 1'b1; req_wr = 1'b0; req_addr = a; req_size = 2'b11;
    @(negedge clk); #4;
    req = 1'b0;
    waited = 0;
    while (beat_idx < 5 && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    check_eq("rst_reach_beat5", beat_idx, 5);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    #3;
    check_eq("rst_en", en, 0);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_addr", addr, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_done", done, 0);
    repeat (4) @(negedge clk);
    #4;
    check_eq("rst_beats_left", exp_beat_q.size(), 0);
    check_eq("rst_rd_left", exp_rd_q.size(), 0);
    exp_beat_q.delete();
    exp_rd_q.delete();
    exp_cpl_q.delete();
  endtask

  // stimulus
  initial begin
    logic [31:0] a;
    bit wr, hold;
    logic [1:0] sz;
    rst = 1'b1; req = 1'b0; req_wr = 1'b0; req_addr = '0; req_size = '0;
    clear_plan();
    repeat (3) @(negedge clk);
    #4;
    check_eq("reset_en_wren", {en, wren}, 0);
    check_eq("reset_addr", addr, 0);
    check_eq("reset_d_in", d_in, 0);
    check_eq("reset_acc_size", acc_size, 0);
    check_eq("reset_pulses", {wd_pop, rd_valid, done, err}, 0);
    check_eq("reset_rd_data", rd_data, 0);
    check_eq("reset_req_ready", req_ready, 1);
    rst = 1'b0;

    clear_plan();
    run_xfer(1'b0, 32'h100, 2'b00, 1'b0);
    clear_plan();
    for (int k = 0; k < 4; k++) wdat[k] = 32'(k + 1);
    run_xfer(1'b1, 32'h200, 2'b01, 1'b1);
    clear_plan();
    plan_stall[2] = 3;
    run_xfer(1'b0, 32'h1000, 2'b10, 1'b0);
    clear_plan();
    run_xfer(1'b0, 32'h102, 2'b01, 1'b0);
    clear_plan();
    plan_stall[0] = TMO;
    run_xfer(1'b0, 32'h300, 2'b01, 1'b0);
    clear_plan();
    plan_stall[3] = TMO + 2;
    run_xfer(1'b1, 32'h400, 2'b10, 1'b0);
    run_reset_case();

    for (int i = 0; i < 40; i++) begin
      clear_plan();
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a = $urandom & 32'hFFFFFFFC;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFC0 | ($urandom & 32'h3C);
      hold = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        a = a | 32'($urandom_range(1, 3));
        hold = 1'b0;
      end
      for (int k = 0; k < 16; k++)
        plan_stall[k] = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, TMO - 1);
      if ($urandom_range(0, 7) == 0) plan_stall[$urandom_range(0, 15)] = TMO + $urandom_range(0, 2);
      run_xfer(wr, a, sz, hold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
